// File: rtl/alu_mdu_seq_if.sv
// Issue/result bus of the EX-stage ALU/MDU: operand handshake, result handshake,
// pipeline flush and busy status.
interface alu_mdu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            err;
  logic            busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, err, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, err, busy
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// RV32/RV64 execute unit: single-cycle base ALU ops plus iterative (1 bit/cycle)
// multiply and divide behind valid/ready handshakes, one op in flight.
module alu_mdu_seq #(
  parameter int unsigned XLEN   = 32,
  parameter bit          MUL_EN = 1'b1,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mdu_seq_if.slave io
);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB  = 5'd1,  OP_AND    = 5'd2,  OP_OR    = 5'd3,
    OP_XOR    = 5'd4,  OP_SLT  = 5'd5,  OP_SLTU   = 5'd6,  OP_SLL   = 5'd7,
    OP_SRL    = 5'd8,  OP_SRA  = 5'd9,  OP_NOP    = 5'd10,
    OP_MUL    = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19,
    OP_DIV    = 5'd20, OP_DIVU = 5'd21, OP_REM    = 5'd22, OP_REMU  = 5'd23
  } op_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_ready;
  logic            accept;
  logic            is_base, is_mul, is_div;
  logic            a_sgn, b_sgn, a_neg, b_neg, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] final_res;

  assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || io.out_ready)
                    && !io.flush;
  assign accept   = io.in_valid && in_ready;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.err       = err_q;
  assign io.busy      = (state_q != S_IDLE);

  // Opcode classification and operand magnitudes for the signed M-ops
  always_comb begin
    is_base = (io.op <= OP_NOP);
    is_mul  = (io.op[4:2] == 3'b100);
    is_div  = (io.op[4:2] == 3'b101);
    a_sgn   = (io.op == OP_MULH) || (io.op == OP_MULHSU) ||
              (io.op == OP_DIV)  || (io.op == OP_REM);
    b_sgn   = (io.op == OP_MULH) || (io.op == OP_DIV) || (io.op == OP_REM);
    a_neg   = a_sgn && io.a[XLEN-1];
    b_neg   = b_sgn && io.b[XLEN-1];
    a_mag   = a_neg ? (~io.a + 1'b1) : io.a;
    b_mag   = b_neg ? (~io.b + 1'b1) : io.b;
    div_ovf = b_sgn && (io.a == {1'b1, {(XLEN-1){1'b0}}}) && (io.b == '1);
  end

  always_comb begin
    shamt    = io.b[SW-1:0];
    base_res = '0;
    case (io.op)
      OP_ADD:  base_res = io.a + io.b;
      OP_SUB:  base_res = io.a - io.b;
      OP_AND:  base_res = io.a & io.b;
      OP_OR:   base_res = io.a | io.b;
      OP_XOR:  base_res = io.a ^ io.b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (io.a < io.b)};
      OP_SLL:  base_res = io.a << shamt;
      OP_SRL:  base_res = io.a >> shamt;
      OP_SRA:  base_res = XLEN'($signed(io.a) >>> shamt);
      default: base_res = '0;
    endcase
  end

  // One iteration: shift-add multiply (product in {hi,lo}) or restoring divide
  // (remainder in hi, quotient shifted into lo). op_q[2] selects divide.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (!op_q[2]) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_hi = div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_sh[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // The last iteration is folded into DONE together with sign correction so the
  // result register loads XLEN cycles after the first iteration.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = neg_q ? (~step_lo + 1'b1) : step_lo;
      OP_REM, OP_REMU:              final_res = neg_rem_q ? (~step_hi + 1'b1) : step_hi;
      default:                      final_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    neg_rem_d   = neg_rem_q;
    out_valid_d = out_valid_q && !io.out_ready;
    result_d    = result_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = io.op;
          if (is_base) begin
            result_d    = base_res;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
          end else if (is_mul && MUL_EN) begin
            state_d   = S_MUL;
            cnt_d     = '0;
            hi_d      = '0;
            lo_d      = b_mag;
            opnd_d    = a_mag;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = 1'b0;
          end else if (is_div && DIV_EN) begin
            if (io.b == '0) begin
              result_d    = io.op[1] ? io.a : '1;
              err_d       = 1'b0;
              out_valid_d = 1'b1;
            end else if (div_ovf) begin
              result_d    = io.op[1] ? '0 : io.a;
              err_d       = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              state_d   = S_DIV;
              cnt_d     = '0;
              hi_d      = '0;
              lo_d      = a_mag;
              opnd_d    = b_mag;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
            end
          end else begin
            result_d    = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(XLEN-2)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q || io.out_ready) begin
          result_d    = final_res;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (io.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      neg_rem_q   <= neg_rem_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  // in_ready only opens with the output register free, so DONE never stalls.
  a_done_no_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_DONE) |-> (!out_valid_q || io.out_ready));

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: vector table for op results/latency plus
// sequences for back-pressure, flush, reset and a MUL_EN=0 build.
module tb_alu_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        t_in_valid = 1'b0;
  logic [4:0]  t_op = '0;
  logic [31:0] t_a = '0;
  logic [31:0] t_b = '0;
  logic        t_out_ready = 1'b1;
  logic        t_flush = 1'b0;
  logic        sel = 1'b0;

  alu_mdu_seq_if #(.XLEN(32)) bus ();
  alu_mdu_seq_if #(.XLEN(32)) bus_nm ();

  assign bus.in_valid     = t_in_valid;
  assign bus.op           = t_op;
  assign bus.a            = t_a;
  assign bus.b            = t_b;
  assign bus.out_ready    = t_out_ready;
  assign bus.flush        = t_flush;
  assign bus_nm.in_valid  = t_in_valid;
  assign bus_nm.op        = t_op;
  assign bus_nm.a         = t_a;
  assign bus_nm.b         = t_b;
  assign bus_nm.out_ready = t_out_ready;
  assign bus_nm.flush     = t_flush;

  alu_mdu_seq #(.XLEN(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus.slave));
  alu_mdu_seq #(.XLEN(32), .MUL_EN(1'b0), .DIV_EN(1'b1)) dut_nm (
    .clk(clk), .rst_n(rst_n), .io(bus_nm.slave));

  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_res;
  assign cur_ready = sel ? bus_nm.in_ready  : bus.in_ready;
  assign cur_valid = sel ? bus_nm.out_valid : bus.out_valid;
  assign cur_err   = sel ? bus_nm.err       : bus.err;
  assign cur_res   = sel ? bus_nm.result    : bus.result;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        nm;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic nm, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input logic err,
                     input int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.res = res; v.err = err; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic do_op(input logic s, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output logic err, output int lat);
    int w;
    @(negedge clk);
    sel = s; t_op = op; t_a = a; t_b = b; t_in_valid = 1'b1;
    w = 0;
    #1;
    while (!cur_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 t_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cur_valid && lat < 200);
    res = cur_res;
    err = cur_err;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    int          w;
    logic        saw_valid;

    add(0, 5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        0, 1);
    add(0, 5'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 0, 1);
    add(0, 5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 1);
    add(0, 5'd3,  32'hF000000F, 32'h000000F0, 32'hF00000FF, 0, 1);
    add(0, 5'd4,  32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 0, 1);
    add(0, 5'd5,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 1);
    add(0, 5'd6,  32'hFFFFFFFF, 32'h1,        32'h0,        0, 1);
    add(0, 5'd7,  32'h1,        32'h24,       32'h10,       0, 1);
    add(0, 5'd8,  32'h80000000, 32'h1F,       32'h1,        0, 1);
    add(0, 5'd9,  32'h80000000, 32'h21,       32'hC0000000, 0, 1);
    add(0, 5'd10, 32'h1234,     32'h5678,     32'h0,        0, 1);
    add(0, 5'd16, 32'h00012345, 32'h100,      32'h01234500, 0, 33);
    add(0, 5'd16, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFF1, 0, 33);
    add(0, 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 33);
    add(0, 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33);
    add(0, 5'd18, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 33);
    add(0, 5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 0, 33);
    add(0, 5'd20, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 33);
    add(0, 5'd22, 32'h7,        32'hFFFFFFFE, 32'h1,        0, 33);
    add(0, 5'd20, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, 33);
    add(0, 5'd22, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, 33);
    add(0, 5'd21, 32'd100,      32'd7,        32'd14,       0, 33);
    add(0, 5'd23, 32'd100,      32'd7,        32'd2,        0, 33);
    add(0, 5'd21, 32'h12345678, 32'h0,        32'hFFFFFFFF, 0, 1);
    add(0, 5'd22, 32'h5,        32'h0,        32'h5,        0, 1);
    add(0, 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1);
    add(0, 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 1);
    add(0, 5'd12, 32'h3,        32'h4,        32'h0,        1, 1);
    add(0, 5'd31, 32'h3,        32'h4,        32'h0,        1, 1);
    add(1, 5'd16, 32'h3,        32'h5,        32'h0,        1, 1);
    add(1, 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1, 1);
    add(1, 5'd21, 32'd9,        32'd3,        32'd3,        0, 33);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result",    bus.result, 0);
    check("rst_err",       bus.err, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_in_ready",  bus.in_ready, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat);
      check($sformatf("v%0d_op%0d_res", i, vecs[i].op), r, vecs[i].res);
      check($sformatf("v%0d_op%0d_err", i, vecs[i].op), e, vecs[i].err);
      check($sformatf("v%0d_op%0d_lat", i, vecs[i].op), lat, vecs[i].lat);
    end
    sel = 1'b0;
    repeat (40) @(posedge clk);

    // Back-pressure: result held, no accept, then accept overlapping drain
    @(negedge clk);
    t_out_ready = 1'b0;
    t_op = 5'd0; t_a = 32'd2; t_b = 32'd3; t_in_valid = 1'b1;
    #1 check("bp_ready0", bus.in_ready, 1);
    @(posedge clk);
    #1 t_op = 5'd1; t_a = 32'd9; t_b = 32'd2;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.out_valid && w < 50);
    check("bp_first_res", bus.result, 32'd5);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d_res", k), bus.result, 32'd5);
      check($sformatf("bp_hold%0d_valid", k), bus.out_valid, 1);
      check($sformatf("bp_hold%0d_ready", k), bus.in_ready, 0);
    end
    t_out_ready = 1'b1;
    #1 check("bp_ready_drain", bus.in_ready, 1);
    @(posedge clk);
    #1 t_in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_res", bus.result, 32'd7);
    repeat (3) @(posedge clk);

    // Flush during a DIV iteration
    @(negedge clk);
    t_op = 5'd20; t_a = 32'd100; t_b = 32'd3; t_in_valid = 1'b1;
    #1 check("fl_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 t_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("fl_busy_before", bus.busy, 1);
    t_flush = 1'b1;
    t_op = 5'd0; t_a = 32'd1; t_b = 32'd1; t_in_valid = 1'b1;
    #1 check("fl_in_ready0", bus.in_ready, 0);
    @(posedge clk);
    #1 t_flush = 1'b0; t_in_valid = 1'b0;
    @(negedge clk);
    check("fl_busy", bus.busy, 0);
    check("fl_out_valid", bus.out_valid, 0);
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("fl_no_result", saw_valid, 0);
    do_op(0, 5'd21, 32'd100, 32'd3, r, e, lat);
    check("fl_next_res", r, 32'd33);
    check("fl_next_lat", lat, 33);

    // Reset in the middle of a MUL
    @(negedge clk);
    t_op = 5'd16; t_a = 32'd3; t_b = 32'd5; t_in_valid = 1'b1;
    #1 check("mr_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 t_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mr_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_out_valid", bus.out_valid, 0);
    check("mr_result", bus.result, 0);
    check("mr_err", bus.err, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    do_op(0, 5'd16, 32'd7, 32'd6, r, e, lat);
    check("mr_after_res", r, 32'd42);
    check("mr_after_lat", lat, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
